// File: rtl/proc_pkg.sv
// Shared processor package: instruction-word layout, opcode map, operand
// type encodings, status bit positions and the decode classification record.
package proc_pkg;

  localparam int BUSW   = 32;  // data / operand width
  localparam int RINDW  = 12;  // register index field width
  localparam int RWORDS = 16;  // implemented registers
  localparam int PSRW   = 5;   // status width

  // Opcodes carried in ir[31:28]; 0xA..0xF are unassigned.
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LD  = 4'h1;
  localparam logic [3:0] OP_STR = 4'h2;
  localparam logic [3:0] OP_BRA = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_ADD = 4'h5;
  localparam logic [3:0] OP_ROT = 4'h6;
  localparam logic [3:0] OP_SHF = 4'h7;
  localparam logic [3:0] OP_HLT = 4'h8;
  localparam logic [3:0] OP_CMP = 4'h9;

  // Operand type bit values.
  localparam logic REGTYPE = 1'b0;
  localparam logic IMMTYPE = 1'b1;

  // Instruction-register field positions.
  localparam int IR_OPC_HI   = 31;
  localparam int IR_OPC_LO   = 28;
  localparam int IR_SRC_TYPE = 27;
  localparam int IR_DST_TYPE = 26;
  localparam int IR_CC_HI    = 26;
  localparam int IR_CC_LO    = 24;
  localparam int IR_SRC_HI   = 23;
  localparam int IR_SRC_LO   = 12;
  localparam int IR_DST_HI   = 11;
  localparam int IR_DST_LO   = 0;

  // Sticky status bit indices.
  localparam int STB_ILL_OPC = 0;
  localparam int STB_IMM_DST = 1;
  localparam int STB_RANGE   = 2;
  localparam int STB_HALT    = 3;
  localparam int STB_ROT_CNT = 4;

  // Decode classification of one instruction word.
  typedef struct packed {
    logic       needs_dst_rd;
    logic       needs_src_rd;
    logic       src_is_imm;
    logic       is_nop;
    logic       is_hlt;
    logic       ill_opc;
    logic       ill_imm_dst;
    logic       ill_range;
    logic       ill_rot_cnt;
    logic [2:0] cc;
  } idec_cls_t;

  // True when a register index points past the implemented bank.
  function automatic logic idx_oor(input logic [RINDW-1:0] idx);
    return (idx >= RINDW'(RWORDS));
  endfunction

endpackage

// File: rtl/instr_decoder_if.sv
// Decoder bus bundle: instruction offer, register-bank read port and
// micro-op issue channel. slave = decoder side, master = environment side.
interface instr_decoder_if;
  import proc_pkg::*;

  logic             ir_valid;
  logic             ir_ready;
  logic [BUSW-1:0]  ir;
  logic             rb_rd_en;
  logic [RINDW-1:0] rb_rd_addr;
  logic [BUSW-1:0]  rb_rd_data;
  logic             uop_valid;
  logic             uop_ready;
  logic [3:0]       uop_opcode;
  logic [RINDW-1:0] uop_dst_idx;
  logic [BUSW-1:0]  uop_dst_val;
  logic [BUSW-1:0]  uop_src_val;
  logic [2:0]       uop_cc;

  modport slave (
    input  ir_valid, ir, rb_rd_data, uop_ready,
    output ir_ready, rb_rd_en, rb_rd_addr,
    output uop_valid, uop_opcode, uop_dst_idx, uop_dst_val, uop_src_val, uop_cc
  );

  modport master (
    output ir_valid, ir, rb_rd_data, uop_ready,
    input  ir_ready, rb_rd_en, rb_rd_addr,
    input  uop_valid, uop_opcode, uop_dst_idx, uop_dst_val, uop_src_val, uop_cc
  );

endinterface

// File: rtl/idec_field_classify.sv
// Combinational field classifier: decides which register reads an
// instruction word needs, whether its source is an immediate, and which
// encoding rules it breaks.
module idec_field_classify
  import proc_pkg::*;
(
  input  logic [BUSW-1:0] ir,
  output idec_cls_t       cls
);

  logic [3:0]       opc_s;
  logic             src_t_s;
  logic             dst_t_s;
  logic [RINDW-1:0] src_idx_s;
  logic [RINDW-1:0] dst_idx_s;
  logic             dst_target_s;

  assign opc_s     = ir[IR_OPC_HI:IR_OPC_LO];
  assign src_t_s   = ir[IR_SRC_TYPE];
  assign dst_t_s   = ir[IR_DST_TYPE];
  assign src_idx_s = ir[IR_SRC_HI:IR_SRC_LO];
  assign dst_idx_s = ir[IR_DST_HI:IR_DST_LO];

  // Per-opcode read needs and rule checks; dst_target marks a register destination.
  always_comb begin
    cls.needs_dst_rd = 1'b0;
    cls.needs_src_rd = 1'b0;
    cls.src_is_imm   = 1'b0;
    cls.is_nop       = 1'b0;
    cls.is_hlt       = 1'b0;
    cls.ill_opc      = 1'b0;
    cls.ill_imm_dst  = 1'b0;
    cls.ill_range    = 1'b0;
    cls.ill_rot_cnt  = 1'b0;
    cls.cc           = 3'd0;
    dst_target_s     = 1'b0;
    case (opc_s)
      OP_NOP: cls.is_nop = 1'b1;
      OP_LD, OP_STR: begin
        cls.needs_src_rd = (src_t_s == REGTYPE);
        cls.src_is_imm   = (src_t_s == IMMTYPE);
        cls.ill_imm_dst  = (dst_t_s == IMMTYPE);
        dst_target_s     = 1'b1;
      end
      OP_BRA: cls.cc = ir[IR_CC_HI:IR_CC_LO];
      OP_XOR, OP_ADD: begin
        cls.needs_dst_rd = 1'b1;
        cls.needs_src_rd = (src_t_s == REGTYPE);
        cls.src_is_imm   = (src_t_s == IMMTYPE);
        cls.ill_imm_dst  = (dst_t_s == IMMTYPE);
        dst_target_s     = 1'b1;
      end
      OP_ROT, OP_SHF: begin
        cls.needs_dst_rd = 1'b1;
        cls.src_is_imm   = 1'b1;
        cls.ill_imm_dst  = (dst_t_s == IMMTYPE);
        cls.ill_rot_cnt  = (src_t_s == REGTYPE);
        dst_target_s     = 1'b1;
      end
      OP_HLT: cls.is_hlt = 1'b1;
      // CMP selects its source type with the bit that is the dst type elsewhere.
      OP_CMP: begin
        cls.needs_src_rd = (dst_t_s == REGTYPE);
        cls.src_is_imm   = (dst_t_s == IMMTYPE);
      end
      default: cls.ill_opc = 1'b1;
    endcase
    cls.ill_range = ((cls.needs_dst_rd || dst_target_s) && idx_oor(dst_idx_s)) ||
                    (cls.needs_src_rd && idx_oor(src_idx_s));
  end

endmodule

// File: rtl/instr_decoder.sv
// Instruction decoder top: accepts one IReg word, fetches its register
// operands over the one-cycle-latency bank port and issues one micro-op.
// Optional feature macro: INSTR_DECODER_ILLEGAL_TRAP_EN (records illegal
// encodings in status); when undefined, illegal words behave as NOP.
module instr_decoder
  import proc_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  instr_decoder_if.slave  bus,
  output logic [PSRW-1:0] status
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DEC    = 3'd1;
  localparam logic [2:0] S_RD_DST = 3'd2;
  localparam logic [2:0] S_RD_SRC = 3'd3;
  localparam logic [2:0] S_CAP    = 3'd4;
  localparam logic [2:0] S_ISSUE  = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  logic [2:0]       state_r;
  logic [BUSW-1:0]  ir_r;
  logic             uop_valid_r;
  logic [3:0]       uop_opcode_r;
  logic [RINDW-1:0] uop_dst_idx_r;
  logic [BUSW-1:0]  uop_dst_val_r;
  logic [BUSW-1:0]  uop_src_val_r;
  logic [2:0]       uop_cc_r;
  logic [PSRW-1:0]  status_r;
  idec_cls_t        cls_s;
  logic             illegal_s;

  // Classification always looks at the latched word, so ir is ignored after acceptance.
  idec_field_classify u_cls (
    .ir  (ir_r),
    .cls (cls_s)
  );

  assign illegal_s = cls_s.ill_opc | cls_s.ill_imm_dst | cls_s.ill_range | cls_s.ill_rot_cnt;

  // Control FSM, operand capture and sticky status.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= S_IDLE;
      ir_r          <= {BUSW{1'b0}};
      uop_valid_r   <= 1'b0;
      uop_opcode_r  <= 4'd0;
      uop_dst_idx_r <= {RINDW{1'b0}};
      uop_dst_val_r <= {BUSW{1'b0}};
      uop_src_val_r <= {BUSW{1'b0}};
      uop_cc_r      <= 3'd0;
      status_r      <= {PSRW{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (bus.ir_valid) begin
            ir_r    <= bus.ir;
            state_r <= S_DEC;
          end
        end
        S_DEC: begin
          if (illegal_s) begin
`ifdef INSTR_DECODER_ILLEGAL_TRAP_EN
            status_r[STB_ILL_OPC] <= status_r[STB_ILL_OPC] | cls_s.ill_opc;
            status_r[STB_IMM_DST] <= status_r[STB_IMM_DST] | cls_s.ill_imm_dst;
            status_r[STB_RANGE]   <= status_r[STB_RANGE]   | cls_s.ill_range;
            status_r[STB_ROT_CNT] <= status_r[STB_ROT_CNT] | cls_s.ill_rot_cnt;
`endif
            state_r <= S_IDLE;
          end else if (cls_s.is_hlt) begin
            status_r[STB_HALT] <= 1'b1;
            state_r            <= S_HALT;
          end else if (cls_s.is_nop) begin
            state_r <= S_IDLE;
          end else begin
            uop_opcode_r  <= ir_r[IR_OPC_HI:IR_OPC_LO];
            uop_dst_idx_r <= ir_r[IR_DST_HI:IR_DST_LO];
            uop_cc_r      <= cls_s.cc;
            uop_dst_val_r <= {BUSW{1'b0}};
            uop_src_val_r <= cls_s.src_is_imm ?
                             {{(BUSW-RINDW){1'b0}}, ir_r[IR_SRC_HI:IR_SRC_LO]} : {BUSW{1'b0}};
            if (cls_s.needs_dst_rd) begin
              state_r <= S_RD_DST;
            end else if (cls_s.needs_src_rd) begin
              state_r <= S_RD_SRC;
            end else begin
              uop_valid_r <= 1'b1;
              state_r     <= S_ISSUE;
            end
          end
        end
        S_RD_DST: state_r <= cls_s.needs_src_rd ? S_RD_SRC : S_CAP;
        S_RD_SRC: begin
          // Data returning now belongs to the dst read issued last cycle.
          if (cls_s.needs_dst_rd) begin
            uop_dst_val_r <= bus.rb_rd_data;
          end
          state_r <= S_CAP;
        end
        S_CAP: begin
          if (cls_s.needs_src_rd) begin
            uop_src_val_r <= bus.rb_rd_data;
          end else begin
            uop_dst_val_r <= bus.rb_rd_data;
          end
          uop_valid_r <= 1'b1;
          state_r     <= S_ISSUE;
        end
        S_ISSUE: begin
          if (bus.uop_ready) begin
            uop_valid_r <= 1'b0;
            state_r     <= S_IDLE;
          end
        end
        S_HALT:  state_r <= S_HALT;
        default: state_r <= S_IDLE;
      endcase
    end
  end

  assign bus.ir_ready    = (state_r == S_IDLE);
  assign bus.rb_rd_en    = (state_r == S_RD_DST) || (state_r == S_RD_SRC);
  assign bus.rb_rd_addr  = (state_r == S_RD_DST) ? ir_r[IR_DST_HI:IR_DST_LO] :
                           (state_r == S_RD_SRC) ? ir_r[IR_SRC_HI:IR_SRC_LO] : {RINDW{1'b0}};
  assign bus.uop_valid   = uop_valid_r;
  assign bus.uop_opcode  = uop_opcode_r;
  assign bus.uop_dst_idx = uop_dst_idx_r;
  assign bus.uop_dst_val = uop_dst_val_r;
  assign bus.uop_src_val = uop_src_val_r;
  assign bus.uop_cc      = uop_cc_r;
  assign status          = status_r;

endmodule

// File: tb/tb_instr_decoder.sv
// Self-checking bench for instr_decoder: table of single-instruction
// vectors plus hand-written stall, halt and reset-in-flight sequences.
// Expected micro-ops go through a scoreboard queue.
module tb_instr_decoder;
  import proc_pkg::*;

`ifdef INSTR_DECODER_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct {
    logic [3:0]  op;
    logic [11:0] dst;
    logic [31:0] dv;
    logic [31:0] sv;
    logic [2:0]  cc;
  } uop_t;

  typedef struct {
    logic [31:0] ir;
    bit          issue;
    int          lat;
    int          nrd;
    logic [11:0] a0;
    logic [11:0] a1;
    uop_t        u;
    logic [4:0]  st;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [PSRW-1:0] status;
  int              errors = 0;
  int              checks = 0;
  int              hs_count = 0;
  logic [31:0]     bank [RWORDS];
  uop_t            sb_q [$];
  logic [11:0]     rd_log [$];
  vec_t            vt [16];

  instr_decoder_if bus ();

  instr_decoder dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus.slave),
    .status (status)
  );

  always #5 clk = ~clk;

  // Register bank model: one-cycle read latency, garbage when not read.
  always @(posedge clk) begin
    if (bus.rb_rd_en) bus.rb_rd_data <= bank[bus.rb_rd_addr[3:0]];
    else              bus.rb_rd_data <= 32'hDEAD_BEEF;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Read-address log and scoreboard compare on every micro-op transfer.
  always @(negedge clk) begin
    if (!rst && bus.rb_rd_en) rd_log.push_back(bus.rb_rd_addr);
    if (!rst && bus.uop_valid && bus.uop_ready) begin
      hs_count++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_uop: got opcode %h expected no transfer", bus.uop_opcode);
      end else begin
        uop_t e;
        e = sb_q.pop_front();
        chk("uop_opcode",  32'(bus.uop_opcode),  32'(e.op));
        chk("uop_dst_idx", 32'(bus.uop_dst_idx), 32'(e.dst));
        chk("uop_dst_val", bus.uop_dst_val, e.dv);
        chk("uop_src_val", bus.uop_src_val, e.sv);
        chk("uop_cc",      32'(bus.uop_cc),      32'(e.cc));
      end
    end
  end

  function automatic vec_t mkv(input logic [31:0] ir, input bit issue, input int lat,
                               input int nrd, input logic [11:0] a0, input logic [11:0] a1,
                               input logic [31:0] dv, input logic [31:0] sv,
                               input logic [2:0] cc, input logic [4:0] st);
    vec_t v;
    v.ir = ir; v.issue = issue; v.lat = lat; v.nrd = nrd; v.a0 = a0; v.a1 = a1;
    v.u.op = ir[31:28]; v.u.dst = ir[11:0]; v.u.dv = dv; v.u.sv = sv; v.u.cc = cc;
    v.st = st;
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.ir_valid = 1'b0;
    bus.uop_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send(input logic [31:0] w);
    bus.ir_valid = 1'b1;
    bus.ir = w;
    @(posedge clk);
    #1;
    bus.ir_valid = 1'b0;
    bus.ir = $urandom;
  endtask

  task automatic wait_uop(output int k);
    k = 0;
    while (!bus.uop_valid && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int k;
    do_reset();
    sb_q.delete();
    rd_log.delete();
    chk($sformatf("v%0d_ready_before", idx), 32'(bus.ir_ready), 32'd1);
    if (v.issue) sb_q.push_back(v.u);
    send(v.ir);
    if (v.issue) begin
      wait_uop(k);
      chk($sformatf("v%0d_latency", idx), k, v.lat);
      k = 0;
      while (!bus.ir_ready && k < 20) begin
        @(posedge clk);
        #1;
        k++;
      end
      chk($sformatf("v%0d_ready_after", idx), 32'(bus.ir_ready), 32'd1);
      chk($sformatf("v%0d_sb_drained", idx), sb_q.size(), 32'd0);
    end else begin
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_ready_t1", idx), 32'(bus.ir_ready), 32'd1);
      repeat (3) begin
        chk($sformatf("v%0d_no_uop", idx), 32'(bus.uop_valid), 32'd0);
        @(posedge clk);
        #1;
      end
    end
    chk($sformatf("v%0d_status", idx), 32'(status), 32'(v.st));
    chk($sformatf("v%0d_nreads", idx), rd_log.size(), v.nrd);
    if (rd_log.size() > 0) chk($sformatf("v%0d_rd_addr0", idx), 32'(rd_log[0]), 32'(v.a0));
    if (rd_log.size() > 1) chk($sformatf("v%0d_rd_addr1", idx), 32'(rd_log[1]), 32'(v.a1));
  endtask

  initial begin
    int k;
    uop_t u;
    bus.ir_valid = 1'b0;
    bus.ir = 32'd0;
    bus.uop_ready = 1'b1;
    for (int i = 0; i < RWORDS; i++) bank[i] = 32'h1357_0000 + 32'(i) * 32'h0000_0111;
    bank[5] = 32'h0000_0010;
    bank[3] = 32'h0000_0022;

    vt[0]  = mkv(32'h5000_3005, 1'b1, 4, 2, 12'd5,  12'd3,  bank[5],  bank[3],  3'd0, 5'b00000);
    vt[1]  = mkv(32'h180A_B002, 1'b1, 1, 0, 12'd0,  12'd0,  32'd0,    32'h0AB,  3'd0, 5'b00000);
    vt[2]  = mkv(32'h3500_000C, 1'b1, 1, 0, 12'd0,  12'd0,  32'd0,    32'd0,    3'd5, 5'b00000);
    vt[3]  = mkv(32'h6000_4007, 1'b0, 0, 0, 12'd0,  12'd0,  32'd0,    32'd0,    3'd0,
                 TRAP ? 5'b10000 : 5'b00000);
    vt[4]  = mkv(32'h1000_3002, 1'b1, 3, 1, 12'd3,  12'd0,  32'd0,    bank[3],  3'd0, 5'b00000);
    vt[5]  = mkv(32'h4805_5004, 1'b1, 3, 1, 12'd4,  12'd0,  bank[4],  32'h055,  3'd0, 5'b00000);
    vt[6]  = mkv(32'h7800_3001, 1'b1, 3, 1, 12'd1,  12'd0,  bank[1],  32'h003,  3'd0, 5'b00000);
    vt[7]  = mkv(32'h9000_7000, 1'b1, 3, 1, 12'd7,  12'd0,  32'd0,    bank[7],  3'd0, 5'b00000);
    vt[8]  = mkv(32'h940A_B000, 1'b1, 1, 0, 12'd0,  12'd0,  32'd0,    32'h0AB,  3'd0, 5'b00000);
    vt[9]  = mkv(32'hA000_0000, 1'b0, 0, 0, 12'd0,  12'd0,  32'd0,    32'd0,    3'd0,
                 TRAP ? 5'b00001 : 5'b00000);
    vt[10] = mkv(32'h5400_3005, 1'b0, 0, 0, 12'd0,  12'd0,  32'd0,    32'd0,    3'd0,
                 TRAP ? 5'b00010 : 5'b00000);
    vt[11] = mkv(32'h5000_3010, 1'b0, 0, 0, 12'd0,  12'd0,  32'd0,    32'd0,    3'd0,
                 TRAP ? 5'b00100 : 5'b00000);
    vt[12] = mkv(32'h5001_0001, 1'b0, 0, 0, 12'd0,  12'd0,  32'd0,    32'd0,    3'd0,
                 TRAP ? 5'b00100 : 5'b00000);
    vt[13] = mkv(32'h0000_0000, 1'b0, 0, 0, 12'd0,  12'd0,  32'd0,    32'd0,    3'd0, 5'b00000);
    vt[14] = mkv(32'h5000_F00F, 1'b1, 4, 2, 12'd15, 12'd15, bank[15], bank[15], 3'd0, 5'b00000);
    vt[15] = mkv(32'h2000_E00D, 1'b1, 3, 1, 12'd14, 12'd0,  32'd0,    bank[14], 3'd0, 5'b00000);

    // Reset state.
    do_reset();
    chk("rst_ir_ready",  32'(bus.ir_ready),    32'd1);
    chk("rst_rb_rd_en",  32'(bus.rb_rd_en),    32'd0);
    chk("rst_uop_valid", 32'(bus.uop_valid),   32'd0);
    chk("rst_opcode",    32'(bus.uop_opcode),  32'd0);
    chk("rst_dst_idx",   32'(bus.uop_dst_idx), 32'd0);
    chk("rst_dst_val",   bus.uop_dst_val,      32'd0);
    chk("rst_src_val",   bus.uop_src_val,      32'd0);
    chk("rst_cc",        32'(bus.uop_cc),      32'd0);
    chk("rst_status",    32'(status),          32'd0);

    for (int i = 0; i < 16; i++) run_vec(i, vt[i]);

    // XOR held under back-pressure, then HLT.
    do_reset();
    sb_q.delete();
    hs_count = 0;
    bus.uop_ready = 1'b0;
    u.op = 4'h4; u.dst = 12'd1; u.dv = bank[1]; u.sv = bank[2]; u.cc = 3'd0;
    sb_q.push_back(u);
    send(32'h4000_2001);
    wait_uop(k);
    chk("stall_latency", k, 32'd4);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("stall_valid",   32'(bus.uop_valid),   32'd1);
      chk("stall_opcode",  32'(bus.uop_opcode),  32'h4);
      chk("stall_dst_idx", 32'(bus.uop_dst_idx), 32'd1);
      chk("stall_dst_val", bus.uop_dst_val,      bank[1]);
      chk("stall_src_val", bus.uop_src_val,      bank[2]);
    end
    chk("stall_no_xfer", hs_count, 32'd0);
    bus.uop_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("stall_valid_drop", 32'(bus.uop_valid), 32'd0);
    chk("stall_one_xfer",   hs_count,           32'd1);
    chk("stall_sb_drained", sb_q.size(),        32'd0);
    chk("hlt_ready_before", 32'(bus.ir_ready),  32'd1);
    bus.ir_valid = 1'b1;
    bus.ir = 32'h8000_0000;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("hlt_status", 32'(status), 32'b01000);
    repeat (5) begin
      chk("hlt_ready_low", 32'(bus.ir_ready),  32'd0);
      chk("hlt_no_uop",    32'(bus.uop_valid), 32'd0);
      @(posedge clk);
      #1;
    end
    bus.ir_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("hlt_rst_ready",  32'(bus.ir_ready), 32'd1);
    chk("hlt_rst_status", 32'(status),       32'd0);

    // Reset while reading the source operand drops the instruction.
    do_reset();
    sb_q.delete();
    hs_count = 0;
    send(32'h5000_3005);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("rdsrc_rd_en",   32'(bus.rb_rd_en),   32'd1);
    chk("rdsrc_rd_addr", 32'(bus.rb_rd_addr), 32'd3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rdsrc_rst_valid",  32'(bus.uop_valid), 32'd0);
    chk("rdsrc_rst_ready",  32'(bus.ir_ready),  32'd1);
    chk("rdsrc_rst_status", 32'(status),        32'd0);
    chk("rdsrc_rst_rd_en",  32'(bus.rb_rd_en),  32'd0);
    repeat (6) @(posedge clk);
    #1;
    chk("rdsrc_no_xfer", hs_count, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
